multi_channel_counter_fsm: RTL and testbench
============================================

# multi_channel_counter_fsm

Parametrised successor to the single 5-bit counter FSM. Provides NUM_CH independent counter channels, each with a programmable terminal count, one-shot or auto-reload mode, pause and abort controls, and a registered done pulse. Sits in the DDS calibration/ranging control path, where it times burst and dwell intervals.

## Interface
Parameters:
- NUM_CH, default 4: number of independent channels (≥1).
- CNT_W, default 5: counter and terminal-count width (≥2).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  NUM_CH  per-channel start request, sampled each cycle.
- abort  in  NUM_CH  per-channel abort; returns the channel to IDLE.
- pause  in  NUM_CH  per-channel hold; freezes the count while high.
- mode  in  NUM_CH  per-channel mode, latched at start: 0 = ONE_SHOT, 1 = AUTO_RELOAD.
- load_val  in  NUM_CH*CNT_W  per-channel terminal count. Channel i uses bits [i*CNT_W +: CNT_W]. Latched at start.
- busy  out  NUM_CH  channel is in START or COUNTING.
- count_value  out  NUM_CH*CNT_W  per-channel current count, packed the same way as load_val.
- done  out  NUM_CH  one-cycle pulse when the count equals the latched target.
- load_err  out  NUM_CH  one-cycle pulse when a start was rejected because load_val was 0.
- any_busy  out  1  OR of all busy bits.

## Operation
Per-channel FSM with states IDLE, START and COUNTING. The channels share no state.
- IDLE: busy=0 and count=0.
  - start=1 with load_val≠0: latch target and mode, then go to START.
  - start=1 with load_val=0: stay in IDLE and pulse load_err.
- START: lasts one cycle. busy=1 and count=0. Always moves to COUNTING; pause does not stall it.
- COUNTING: busy=1.
  - pause=0: count increments by 1.
  - pause=1: count holds.
  - When count==target, done=1 for exactly that cycle. On the next edge:
    - ONE_SHOT: go to IDLE with count=0.
    - AUTO_RELOAD: count←0, stay in COUNTING, and issue a done pulse every target+1 cycles.
  - pause=1 while count==target holds the count and the state. done stays high only for the first cycle. The wrap or exit happens on the first un-paused edge.
- Priority per channel, highest first:
  1. abort: go to IDLE, count←0. No done and no load_err.
  2. start: accepted only in IDLE.
  3. pause.
  4. normal counting.
- A start while busy is ignored; it does not retarget the channel.
- A start in the same cycle as a one-shot done is ignored. The channel needs a new start once it is in IDLE.
- The counter never exceeds target, so there is no CNT_W overflow. A target of 2^CNT_W−1 is legal.
- The design has no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, any time, including mid-count):
  - All channels go to IDLE.
  - busy, count_value, done, load_err and any_busy are all 0.
  - Latched target and mode are cleared to 0.
  - Deasserting rst takes effect on the next edge.
- Start accepted at edge T:
  - busy=1 and count=0 from T+1 (START).
  - count=k at T+1+k.
  - done=1 at T+1+target.
  - ONE_SHOT: busy=0 at T+2+target, so the channel is busy for target+1 cycles.
  - Each pause cycle adds 1 cycle of latency.
- abort at edge T: busy=0 and count=0 from T+1. A done scheduled for T+1 is suppressed.
- load_err is asserted at T+1 for a rejected start at T.
- any_busy has the same latency as busy.

## Structure
- The shared package holds:
  - typedef enum state_e {IDLE, START, COUNTING}
  - typedef enum mode_e {ONE_SHOT, AUTO_RELOAD}
  - bench scoreboard counters for busy, count and done mismatches.
- Parameter-dependent widths stay in the module, not the package.
- One sub-module, counter_channel (parameter CNT_W), contains one FSM and its counter. The top level instantiates NUM_CH copies in a generate loop, packs the buses and ORs the busy bits into any_busy.

## Test plan
- Reset and idle:
  - Assert rst mid-count on ch0 (count=3): all outputs read 0 immediately.
  - After release, start ch0 with load_val=4: done at T+5, busy low at T+6.
- Auto-reload:
  - Start ch1 in AUTO_RELOAD with load_val=3: done pulses at T+4, T+8, T+12.
  - Count sequence is 0,0,1,2,3,0,1,2,3…
- Pause:
  - Start ch2 with load_val=5; pause for 3 cycles at count=2: done at T+9.
  - Pause held at count==target: a single done pulse, and the exit is delayed.
- Zero load and restart:
  - Start ch3 with load_val=0: load_err pulse, and busy stays 0.
  - Start while busy (target 6, restart with 2): the count still reaches 6.
- Simultaneous events:
  - abort and start in the same cycle: channel goes to IDLE.
  - abort in the done-scheduled cycle: no done.
  - start in the same cycle as a one-shot done: ignored.
- Independence:
  - Run all 4 channels with targets 1, 7, 31 and 31 in mixed modes, using CNT_W=5 and NUM_CH=4, plus a CNT_W=8 build with target 255.
  - Each channel matches the reference model, and any_busy equals the OR of busy.

Source files
------------

// File: rtl/multi_channel_counter_fsm_pkg.sv
// Shared types for the multi-channel counter FSM.
//   state_e  : per-channel FSM state (IDLE, START, COUNTING)
//   mode_e   : per-channel reload mode, latched at start
//   sb_cnt_t : mismatch tallies kept by the bench scoreboard
// Parameter-dependent widths live in the modules, not here.
package multi_channel_counter_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        COUNTING = 2'd2
    } state_e;

    typedef enum logic {
        ONE_SHOT    = 1'b0,
        AUTO_RELOAD = 1'b1
    } mode_e;

    typedef struct packed {
        logic [15:0] busy_err;
        logic [15:0] count_err;
        logic [15:0] done_err;
        logic [15:0] other_err;
    } sb_cnt_t;

endpackage

// File: rtl/multi_channel_counter_fsm_counter_channel.sv
// One counter channel: IDLE -> START -> COUNTING FSM with programmable
// terminal count, one-shot / auto-reload mode, pause and abort.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : start request (accepted only in IDLE)
//   abort      : return to IDLE, highest priority
//   pause      : freeze the count while high (COUNTING only)
//   mode       : 0 = one-shot, 1 = auto-reload (latched at start)
//   load_val   : terminal count (latched at start, 0 is rejected)
//   busy       : channel in START or COUNTING
//   count      : current count
//   done       : one-cycle pulse in the cycle count equals the target
//   load_err   : one-cycle pulse after a start rejected for load_val == 0
//   state_dbg  : current FSM state
// Every output comes straight from a flop or a decode of flops only.
module counter_channel
    import multi_channel_counter_fsm_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             load_err,
    output state_e           state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;
    logic [CNT_W-1:0] count_inc;

    // count_q never exceeds target_q, so the increment cannot wrap.
    assign count_inc = count_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        count_d    = count_q;
        target_d   = target_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            count_d = CNT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = CNT_ZERO;
                    if (start) begin
                        if (load_val != CNT_ZERO) begin
                            target_d = load_val;
                            mode_d   = mode_e'(mode);
                            state_d  = START;
                        end else begin
                            load_err_d = 1'b1;
                        end
                    end
                end
                START: begin
                    // Single fixed cycle; pause is not honoured here.
                    state_d = COUNTING;
                    count_d = CNT_ONE;
                    done_d  = (target_q == CNT_ONE);
                end
                COUNTING: begin
                    // done is raised only on the edge that reaches the
                    // target, so a pause held at the target yields one pulse.
                    if (!pause) begin
                        if (count_q == target_q) begin
                            count_d = CNT_ZERO;
                            if (mode_q == ONE_SHOT) begin
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_inc;
                            done_d  = (count_inc == target_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= ONE_SHOT;
            count_q    <= CNT_ZERO;
            target_q   <= CNT_ZERO;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            target_q   <= target_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign count     = count_q;
    assign done      = done_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/multi_channel_counter_fsm.sv
// NUM_CH independent counter channels with packed per-channel buses.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   start/abort/pause/mode : per-channel controls, one bit per channel
//   load_val     : per-channel terminal count, channel i at [i*CNT_W +: CNT_W]
//   busy, done, load_err   : per-channel status bits
//   count_value  : per-channel count, packed like load_val
//   any_busy     : OR of all busy bits
//   state_dbg    : per-channel FSM state, channel i at [2*i +: 2]
module multi_channel_counter_fsm
    import multi_channel_counter_fsm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*CNT_W-1:0] count_value,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       load_err,
    output logic                    any_busy,
    output logic [2*NUM_CH-1:0]     state_dbg
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e ch_state;

        counter_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .start     (start[i]),
            .abort     (abort[i]),
            .pause     (pause[i]),
            .mode      (mode[i]),
            .load_val  (load_val[i*CNT_W +: CNT_W]),
            .busy      (busy[i]),
            .count     (count_value[i*CNT_W +: CNT_W]),
            .done      (done[i]),
            .load_err  (load_err[i]),
            .state_dbg (ch_state)
        );

        assign state_dbg[2*i +: 2] = ch_state;
    end

    // busy bits are decoded from state flops, so this stays input-free.
    assign any_busy = |busy;

endmodule

// File: tb/tb_multi_channel_counter_fsm.sv
module tb_multi_channel_counter_fsm;
    import multi_channel_counter_fsm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start, abort, pause, mode;
    logic [19:0] load_val;
    logic [3:0]  busy, done, load_err;
    logic [19:0] count_value;
    logic        any_busy;
    logic [7:0]  state_dbg;

    logic        start8, abort8, pause8, mode8;
    logic [7:0]  load8;
    logic        busy8, done8, lerr8, any8;
    logic [7:0]  cnt8;
    logic [1:0]  st8;

    int      errors = 0;
    int      checks = 0;
    sb_cnt_t sb = '0;

    multi_channel_counter_fsm #(.NUM_CH(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .mode(mode), .load_val(load_val), .busy(busy), .count_value(count_value),
        .done(done), .load_err(load_err), .any_busy(any_busy), .state_dbg(state_dbg)
    );

    multi_channel_counter_fsm #(.NUM_CH(1), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .pause(pause8),
        .mode(mode8), .load_val(load8), .busy(busy8), .count_value(cnt8),
        .done(done8), .load_err(lerr8), .any_busy(any8), .state_dbg(st8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (tag.len() > 0 && tag[0] == "b")      sb.busy_err  = sb.busy_err + 16'd1;
            else if (tag.len() > 0 && tag[0] == "c") sb.count_err = sb.count_err + 16'd1;
            else if (tag.len() > 0 && tag[0] == "d") sb.done_err  = sb.done_err + 16'd1;
            else                                     sb.other_err = sb.other_err + 16'd1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(count_value[ch*5 +: 5]);
    endfunction

    // Reference: t = cycles since the accepting edge (t=1 is START).
    function automatic int e_cnt(input int t, input int tgt, input bit m);
        if (t <= 1) return 0;
        if (m) return (t - 1) % (tgt + 1);
        return (t <= tgt + 1) ? t - 1 : 0;
    endfunction

    function automatic int e_done(input int t, input int tgt, input bit m);
        return (t >= 2 && e_cnt(t, tgt, m) == tgt) ? 1 : 0;
    endfunction

    function automatic int e_busy(input int t, input int tgt, input bit m);
        return (m || t <= tgt + 1) ? 1 : 0;
    endfunction

    task automatic set_ch(input int ch, input int tgt, input bit m);
        load_val[ch*5 +: 5] = 5'(tgt);
        mode[ch] = m;
    endtask

    task automatic go(input int ch);
        start[ch] = 1'b1;
        step();
        start[ch] = 1'b0;
    endtask

    task automatic check_ch(input int ch, input int t, input int tgt, input bit m);
        check($sformatf("cnt%0d_t%0d", ch, t), cnt(ch), e_cnt(t, tgt, m));
        check($sformatf("done%0d_t%0d", ch, t), 32'(done[ch]), e_done(t, tgt, m));
        check($sformatf("busy%0d_t%0d", ch, t), 32'(busy[ch]), e_busy(t, tgt, m));
    endtask

    task automatic run_win(input int ch, input int tgt, input bit m, input int n);
        for (int t = 1; t <= n; t++) begin
            if (t > 1) step();
            check_ch(ch, t, tgt, m);
        end
    endtask

    initial begin
        start = '0; abort = '0; pause = '0; mode = '0; load_val = '0;
        start8 = 1'b0; abort8 = 1'b0; pause8 = 1'b0; mode8 = 1'b0; load8 = '0;

        // Reset state
        step(); step();
        check("busy_rst", 32'(busy), 0);
        check("cnt_rst", 32'(count_value), 0);
        check("done_rst", 32'(done), 0);
        check("lerr_rst", 32'(load_err), 0);
        check("any_rst", 32'(any_busy), 0);
        check("state_rst", 32'(state_dbg), 0);
        check("state8_rst", 32'(st8), 0);
        rst = 1'b0;
        step();

        // Asynchronous reset mid-count at count=3
        set_ch(0, 4, 0);
        go(0);
        step(); step(); step();
        check("cnt0_pre_rst", cnt(0), 3);
        #2 rst = 1'b1;
        #1;
        check("busy_arst", 32'(busy), 0);
        check("cnt_arst", 32'(count_value), 0);
        check("done_arst", 32'(done), 0);
        check("any_arst", 32'(any_busy), 0);
        step();
        rst = 1'b0;
        step();

        // One-shot target 4: done at T+5, idle at T+6
        set_ch(0, 4, 0);
        go(0);
        run_win(0, 4, 0, 7);

        // Auto-reload target 3 on ch1: done at T+4, T+8, T+12
        set_ch(1, 3, 1);
        go(1);
        run_win(1, 3, 1, 12);
        abort[1] = 1'b1;
        step();
        abort[1] = 1'b0;
        check("busy1_abort", 32'(busy[1]), 0);
        check("cnt1_abort", cnt(1), 0);

        // Pause 3 cycles at count=2, target 5: done at T+9
        set_ch(2, 5, 0);
        go(2);
        step(); step();
        check("cnt2_p_t3", cnt(2), 2);
        pause[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("cnt2_paused", cnt(2), 2);
            check("busy2_paused", 32'(busy[2]), 1);
        end
        pause[2] = 1'b0;
        step();
        check("cnt2_t7", cnt(2), 3);
        step();
        check("done2_t8", 32'(done[2]), 0);
        step();
        check("done2_t9", 32'(done[2]), 1);
        check("cnt2_t9", cnt(2), 5);
        step();
        check("busy2_t10", 32'(busy[2]), 0);

        // Pause held at target: single done, delayed exit
        set_ch(2, 2, 0);
        go(2);
        step(); step();
        check("done2_tgt", 32'(done[2]), 1);
        pause[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("done2_hold", 32'(done[2]), 0);
            check("cnt2_hold", cnt(2), 2);
            check("busy2_hold", 32'(busy[2]), 1);
        end
        pause[2] = 1'b0;
        step();
        check("busy2_exit", 32'(busy[2]), 0);
        check("cnt2_exit", cnt(2), 0);

        // Zero load rejected
        set_ch(3, 0, 0);
        go(3);
        check("lerr3_zero", 32'(load_err[3]), 1);
        check("busy3_zero", 32'(busy[3]), 0);
        step();
        check("lerr3_clear", 32'(load_err[3]), 0);

        // Start while busy does not retarget
        set_ch(3, 6, 0);
        go(3);
        step();
        set_ch(3, 2, 0);
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        check("cnt3_restart", cnt(3), 2);
        step(); step(); step(); step();
        check("cnt3_t7", cnt(3), 6);
        check("done3_t7", 32'(done[3]), 1);
        step();
        check("busy3_t8", 32'(busy[3]), 0);

        // abort with start on an idle channel
        set_ch(0, 3, 0);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        step();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("busy0_abst", 32'(busy[0]), 0);
        check("lerr0_abst", 32'(load_err[0]), 0);
        step();
        check("busy0_abst2", 32'(busy[0]), 0);

        // abort in the cycle before a scheduled done
        set_ch(0, 2, 0);
        go(0);
        step();
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("done0_abort", 32'(done[0]), 0);
        check("busy0_abort", 32'(busy[0]), 0);
        check("cnt0_abort", cnt(0), 0);

        // start during a one-shot done cycle is ignored
        set_ch(0, 2, 0);
        go(0);
        step(); step();
        check("done0_os", 32'(done[0]), 1);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("busy0_os_start", 32'(busy[0]), 0);
        step();
        check("busy0_os_after", 32'(busy[0]), 0);

        // Independence: targets 1,7,31,31, modes auto/one/one/auto
        set_ch(0, 1, 1);
        set_ch(1, 7, 0);
        set_ch(2, 31, 0);
        set_ch(3, 31, 1);
        start = 4'hF;
        step();
        start = '0;
        for (int t = 1; t <= 34; t++) begin
            if (t > 1) step();
            check_ch(0, t, 1, 1);
            check_ch(1, t, 7, 0);
            check_ch(2, t, 31, 0);
            check_ch(3, t, 31, 1);
            check($sformatf("any_t%0d", t), 32'(any_busy),
                  32'(e_busy(t, 1, 1) | e_busy(t, 7, 0) | e_busy(t, 31, 0) | e_busy(t, 31, 1)));
        end
        abort = 4'hF;
        step();
        abort = '0;
        check("any_abort_all", 32'(any_busy), 0);

        // CNT_W=8 build, one-shot target 255
        load8 = 8'd255;
        mode8 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int t = 1; t <= 258; t++) begin
            if (t > 1) step();
            check($sformatf("cnt8_t%0d", t), 32'(cnt8), e_cnt(t, 255, 0));
            check($sformatf("done8_t%0d", t), 32'(done8), e_done(t, 255, 0));
            check($sformatf("busy8_t%0d", t), 32'(busy8), e_busy(t, 255, 0));
        end
        check("any8_end", 32'(any8), 0);
        check("lerr8_end", 32'(lerr8), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
